// File: rtl/fcpu_pkg.sv
// Shared core parameters and reorder-buffer types.
// Exports RSV_ID_W/REG_ADDR_W/DATA_W, ROB_DEPTH, ROB_PTR_W and rob_entry_t.
package fcpu_pkg;
  localparam int RSV_ID_W   = 3;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int ROB_DEPTH  = 2**RSV_ID_W;
  localparam int ROB_PTR_W  = RSV_ID_W + 1;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic                  has_dest;
    logic                  inval;
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0]     data;
  } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, result-bus and commit signals of the reorder buffer.
// master: pipeline side (drives alloc/cdb); slave: the reorder buffer.
interface reorder_buffer_if;
  import fcpu_pkg::*;

  logic                  alloc_valid;
  logic                  alloc_has_dest;
  logic [REG_ADDR_W-1:0] alloc_reg_addr;
  logic                  alloc_ready;
  logic [RSV_ID_W-1:0]   alloc_id;

  logic                  cdb_valid;
  logic [RSV_ID_W-1:0]   cdb_id;
  logic [DATA_W-1:0]     cdb_data;
  logic                  cdb_invalidate;

  logic                  we;
  logic                  we_invalidate;
  logic [RSV_ID_W-1:0]   wrQueAddr;
  logic [REG_ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0]     wrData;

  modport master (
    output alloc_valid, alloc_has_dest, alloc_reg_addr,
    output cdb_valid, cdb_id, cdb_data, cdb_invalidate,
    input  alloc_ready, alloc_id,
    input  we, we_invalidate, wrQueAddr, wrAddr, wrData
  );

  modport slave (
    input  alloc_valid, alloc_has_dest, alloc_reg_addr,
    input  cdb_valid, cdb_id, cdb_data, cdb_invalidate,
    output alloc_ready, alloc_id,
    output we, we_invalidate, wrQueAddr, wrAddr, wrData
  );
endinterface

// File: rtl/rob_ptr.sv
// Wrap-bit queue pointer with increment, clear and peer compare.
// Ports: clk, clr, inc, peer -> ptr, same (equal), wrapped (full distance).
module rob_ptr
  import fcpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 inc,
  input  logic [ROB_PTR_W-1:0] peer,
  output logic [ROB_PTR_W-1:0] ptr,
  output logic                 same,
  output logic                 wrapped
);
  always_ff @(posedge clk) begin
    if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + ROB_PTR_W'(1);
  end

  assign same    = (ptr == peer);
  assign wrapped = (ptr[RSV_ID_W-1:0] == peer[RSV_ID_W-1:0])
                && (ptr[RSV_ID_W] != peer[RSV_ID_W]);
endmodule

// File: rtl/reorder_buffer.sv
// In-order commit queue: tags dispatch, gathers results, retires in order.
// Ports: clk, rst, bus (alloc/cdb/commit), flush, rd_ids/rd_data/rd_done, empty, full.
module reorder_buffer
  import fcpu_pkg::*;
#(
  parameter int N_RD_PORTS = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  reorder_buffer_if.slave                      bus,
  input  logic                                 flush,
  input  logic [N_RD_PORTS-1:0][RSV_ID_W-1:0]  rd_ids,
  output logic [N_RD_PORTS-1:0][DATA_W-1:0]    rd_data,
  output logic [N_RD_PORTS-1:0]                rd_done,
  output logic                                 empty,
  output logic                                 full
);
  rob_entry_t           rob_q [ROB_DEPTH];
  logic [ROB_PTR_W-1:0] head;
  logic [ROB_PTR_W-1:0] tail;
  logic [RSV_ID_W-1:0]  hidx;
  logic [RSV_ID_W-1:0]  tidx;
  logic                 h_same, h_wrap;
  logic                 t_same, t_wrap;
  logic                 do_alloc;
  logic                 do_commit;
  logic                 clr;

  assign hidx      = head[RSV_ID_W-1:0];
  assign tidx      = tail[RSV_ID_W-1:0];
  assign clr       = rst | flush;
  assign do_alloc  = bus.alloc_valid & ~full;
  assign do_commit = rob_q[hidx].busy & rob_q[hidx].done;

  rob_ptr u_head (
    .clk     (clk),
    .clr     (clr),
    .inc     (do_commit),
    .peer    (tail),
    .ptr     (head),
    .same    (h_same),
    .wrapped (h_wrap)
  );

  rob_ptr u_tail (
    .clk     (clk),
    .clr     (clr),
    .inc     (do_alloc),
    .peer    (head),
    .ptr     (tail),
    .same    (t_same),
    .wrapped (t_wrap)
  );

  assign empty           = h_same & t_same;
  assign full            = h_wrap & t_wrap;
  assign bus.alloc_ready = ~full;
  assign bus.alloc_id    = tidx;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rob_q[i].busy <= 1'b0;
        rob_q[i].done <= 1'b0;
      end
      bus.we            <= 1'b0;
      bus.we_invalidate <= 1'b0;
      bus.wrQueAddr     <= '0;
      bus.wrAddr        <= '0;
      bus.wrData        <= '0;
    end else if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++)
        rob_q[i].busy <= 1'b0;
      bus.we            <= 1'b0;
      bus.we_invalidate <= 1'b0;
    end else begin
      // Uses pre-edge busy/done, so a result never commits in its own cycle.
      if (bus.cdb_valid && rob_q[bus.cdb_id].busy) begin
        rob_q[bus.cdb_id].done  <= 1'b1;
        rob_q[bus.cdb_id].data  <= bus.cdb_data;
        rob_q[bus.cdb_id].inval <= bus.cdb_invalidate;
      end
      if (do_commit) begin
        rob_q[hidx].busy  <= 1'b0;
        bus.we            <= rob_q[hidx].has_dest;
        bus.we_invalidate <= rob_q[hidx].has_dest & rob_q[hidx].inval;
        if (rob_q[hidx].has_dest) begin
          bus.wrQueAddr <= hidx;
          bus.wrAddr    <= rob_q[hidx].reg_addr;
          bus.wrData    <= rob_q[hidx].data;
        end
      end else begin
        bus.we            <= 1'b0;
        bus.we_invalidate <= 1'b0;
      end
      if (do_alloc) begin
        rob_q[tidx].busy     <= 1'b1;
        rob_q[tidx].done     <= 1'b0;
        rob_q[tidx].inval    <= 1'b0;
        rob_q[tidx].has_dest <= bus.alloc_has_dest;
        rob_q[tidx].reg_addr <= bus.alloc_reg_addr;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_RD_PORTS; i++) begin
      rd_done[i] = rob_q[rd_ids[i]].busy & rob_q[rd_ids[i]].done;
      rd_data[i] = rob_q[rd_ids[i]].data;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a queue-based reference model.
// Model steps on each rising edge; outputs compared on each falling edge.
module tb_reorder_buffer;
  import fcpu_pkg::*;

  typedef struct {
    logic [2:0]  tag;
    bit          has_dest;
    logic [4:0]  rg;
    bit          done;
    bit          inval;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [1:0][2:0]  rd_ids;
  logic [1:0][31:0] rd_data;
  logic [1:0]       rd_done;
  logic empty, full;

  reorder_buffer_if bus ();

  reorder_buffer #(.N_RD_PORTS(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .flush   (flush),
    .rd_ids  (rd_ids),
    .rd_data (rd_data),
    .rd_done (rd_done),
    .empty   (empty),
    .full    (full)
  );

  always #5 clk = ~clk;

  ent_t        q [$];
  int          ntag = 0;
  bit          e_we = 0, e_wi = 0;
  logic [2:0]  e_qa = '0;
  logic [4:0]  e_wa = '0;
  logic [31:0] e_wd = '0;
  bit          chk_en = 0;
  int          nvec = 0;
  int          nerr = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int   pre;
    bit   com;
    ent_t h;
    ent_t n;
    if (rst) begin
      q.delete(); ntag = 0;
      e_we = 0; e_wi = 0; e_qa = '0; e_wa = '0; e_wd = '0;
    end else if (flush) begin
      q.delete(); ntag = 0;
      e_we = 0; e_wi = 0;
    end else begin
      pre = q.size();
      com = (pre > 0) && q[0].done;
      if (com) h = q[0];
      if (bus.cdb_valid)
        foreach (q[k])
          if (q[k].tag == bus.cdb_id) begin
            q[k].done  = 1;
            q[k].data  = bus.cdb_data;
            q[k].inval = bus.cdb_invalidate;
          end
      e_we = 0; e_wi = 0;
      if (com) begin
        void'(q.pop_front());
        if (h.has_dest) begin
          e_we = 1; e_wi = h.inval;
          e_qa = h.tag; e_wa = h.rg; e_wd = h.data;
        end
      end
      if (bus.alloc_valid && pre < ROB_DEPTH) begin
        n.tag = 3'(ntag); n.has_dest = bus.alloc_has_dest;
        n.rg = bus.alloc_reg_addr; n.done = 0; n.inval = 0; n.data = '0;
        q.push_back(n);
        ntag = (ntag + 1) % ROB_DEPTH;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      bit          fd;
      logic [31:0] fdat;
      chk("we", 32'(bus.we), 32'(e_we));
      chk("we_invalidate", 32'(bus.we_invalidate), 32'(e_wi));
      chk("wrQueAddr", 32'(bus.wrQueAddr), 32'(e_qa));
      chk("wrAddr", 32'(bus.wrAddr), 32'(e_wa));
      chk("wrData", bus.wrData, e_wd);
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == ROB_DEPTH));
      chk("alloc_ready", 32'(bus.alloc_ready), 32'(q.size() != ROB_DEPTH));
      chk("alloc_id", 32'(bus.alloc_id), 32'(ntag));
      for (int p = 0; p < 2; p++) begin
        fd = 0; fdat = '0;
        foreach (q[k])
          if (q[k].tag == rd_ids[p] && q[k].done) begin
            fd = 1; fdat = q[k].data;
          end
        chk("rd_done", 32'(rd_done[p]), 32'(fd));
        if (fd) chk("rd_data", rd_data[p], fdat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0;
    bus.alloc_valid = 0; bus.alloc_has_dest = 0; bus.alloc_reg_addr = '0;
    bus.cdb_valid = 0; bus.cdb_id = '0; bus.cdb_data = '0;
    bus.cdb_invalidate = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic alloc(input logic [4:0] rg, input bit hd);
    idle();
    bus.alloc_valid = 1; bus.alloc_has_dest = hd; bus.alloc_reg_addr = rg;
    tick(); idle();
  endtask

  task automatic result(input logic [2:0] id, input logic [31:0] d, input bit inv);
    idle();
    bus.cdb_valid = 1; bus.cdb_id = id; bus.cdb_data = d;
    bus.cdb_invalidate = inv;
    tick(); idle();
  endtask

  initial begin
    rd_ids = '0;
    idle();
    @(negedge clk); #1;
    do_reset();
    chk_en = 1;

    // 1: single instruction end to end
    chk("rst_alloc_id", 32'(bus.alloc_id), 32'd0);
    chk("rst_ready", 32'(bus.alloc_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_we", 32'(bus.we), 32'd0);
    alloc(5'd5, 1);
    result(3'd0, 32'h1234, 0);
    chk("t1_we_early", 32'(bus.we), 32'd0);
    tick();
    chk("t1_we", 32'(bus.we), 32'd1);
    chk("t1_qa", 32'(bus.wrQueAddr), 32'd0);
    chk("t1_wa", 32'(bus.wrAddr), 32'd5);
    chk("t1_wd", bus.wrData, 32'h1234);
    tick();
    chk("t1_we_off", 32'(bus.we), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);

    // 2: out-of-order completion, in-order commit
    do_reset();
    alloc(5'd1, 1); alloc(5'd2, 1); alloc(5'd3, 1);
    result(3'd2, 32'h22, 0);
    result(3'd0, 32'h00, 0);
    chk("t2_no_commit", 32'(bus.we), 32'd0);
    result(3'd1, 32'h11, 0);
    chk("t2_c0", 32'(bus.wrQueAddr), 32'd0);
    chk("t2_c0_reg", 32'(bus.wrAddr), 32'd1);
    tick();
    chk("t2_c1", 32'(bus.wrQueAddr), 32'd1);
    tick();
    chk("t2_c2", 32'(bus.wrQueAddr), 32'd2);
    chk("t2_c2_wd", bus.wrData, 32'h22);
    tick();

    // 3: full queue, stall on retire cycle, wraparound
    do_reset();
    for (int i = 0; i < 8; i++) alloc(5'(i + 8), 1);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_ready", 32'(bus.alloc_ready), 32'd0);
    chk("t3_id", 32'(bus.alloc_id), 32'd0);
    result(3'd0, 32'hA0, 0);
    bus.alloc_valid = 1; bus.alloc_has_dest = 1; bus.alloc_reg_addr = 5'd20;
    tick();
    chk("t3_commit", 32'(bus.we), 32'd1);
    chk("t3_ready2", 32'(bus.alloc_ready), 32'd1);
    chk("t3_id2", 32'(bus.alloc_id), 32'd0);
    tick(); idle();
    chk("t3_full2", 32'(full), 32'd1);
    chk("t3_id3", 32'(bus.alloc_id), 32'd1);
    for (int i = 1; i < 8; i++) result(3'(i), 32'(i * 16), 0);
    result(3'd0, 32'h900d, 0);
    repeat (4) tick();
    chk("t3_empty", 32'(empty), 32'd1);
    chk("t3_wrap_wa", 32'(bus.wrAddr), 32'd20);
    chk("t3_wrap_wd", bus.wrData, 32'h900d);

    // 4: invalidated result and no-dest retire
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(i + 1), 1);
    alloc(5'd9, 0);
    result(3'd0, 32'h10, 0);
    result(3'd1, 32'h11, 0);
    result(3'd2, 32'h12, 0);
    result(3'd3, 32'h13, 1);
    result(3'd4, 32'h14, 0);
    chk("t4_we", 32'(bus.we), 32'd1);
    chk("t4_wi", 32'(bus.we_invalidate), 32'd1);
    chk("t4_qa", 32'(bus.wrQueAddr), 32'd3);
    tick();
    chk("t4_nodest_we", 32'(bus.we), 32'd0);
    chk("t4_nodest_qa", 32'(bus.wrQueAddr), 32'd3);
    chk("t4_empty", 32'(empty), 32'd1);

    // 5: flush discards everything
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(i + 1), 1);
    result(3'd1, 32'h51, 0);
    result(3'd2, 32'h52, 0);
    flush = 1; bus.alloc_valid = 1; bus.alloc_has_dest = 1;
    bus.cdb_valid = 1; bus.cdb_id = 3'd3; bus.cdb_data = 32'h53;
    tick(); idle();
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_id", 32'(bus.alloc_id), 32'd0);
    chk("t5_we", 32'(bus.we), 32'd0);
    rd_ids[0] = 3'd1;
    result(3'd1, 32'hDEAD, 0);
    chk("t5_stale", 32'(rd_done[0]), 32'd0);
    chk("t5_empty2", 32'(empty), 32'd1);

    // 6: bypass reads and mid-stream reset
    do_reset();
    for (int i = 0; i < 5; i++) alloc(5'(i + 1), 1);
    result(3'd4, 32'hCAFE, 0);
    rd_ids[0] = 3'd4; rd_ids[1] = 3'd2;
    tick();
    chk("t6_rd_done0", 32'(rd_done[0]), 32'd1);
    chk("t6_rd_data0", rd_data[0], 32'hCAFE);
    chk("t6_rd_done1", 32'(rd_done[1]), 32'd0);
    result(3'd0, 32'h60, 0);
    rst = 1; tick(); rst = 0;
    chk("t6_rst_we", 32'(bus.we), 32'd0);
    chk("t6_rst_empty", 32'(empty), 32'd1);
    chk("t6_rst_id", 32'(bus.alloc_id), 32'd0);
    chk("t6_rst_wd", bus.wrData, 32'd0);
    chk("t6_rst_rd", 32'(rd_done[0]), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order commit queue between dispatch/execute and `register_file`.
- Hands out a rename tag (`rob_id`) per dispatched instruction and collects out-of-order results from the result bus.
- Retires entries strictly in allocation order onto the register-file commit port (`we` / `we_invalidate` / `wrQueAddr` / `wrAddr` / `wrData`).
- Provides tag-indexed bypass reads, so dispatch can fetch a value that is complete but not yet committed.

Parameters:
- `N_RD_PORTS`, 2, number of tag-indexed bypass read ports.
- Depth is fixed at 2**`RSV_ID_W` entries; `RSV_ID_W`, `REG_ADDR_W` and `DATA_W` come from `fcpu_pkg`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `alloc_valid`  in  1  dispatch requests an entry.
- `alloc_has_dest`  in  1  instruction writes a register.
- `alloc_reg_addr`  in  `REG_ADDR_W`  destination register.
- `alloc_ready`  out  1  entry available; equals !`full`.
- `alloc_id`  out  `RSV_ID_W`  tag of the next entry (tail); drives `register_file.rob_id`.
- `cdb_valid`  in  1  a result is broadcast.
- `cdb_id`  in  `RSV_ID_W`  tag of the result.
- `cdb_data`  in  `DATA_W`  result value.
- `cdb_invalidate`  in  1  result must not update architectural state.
- `flush`  in  1  discard all entries.
- `rd_ids`  in  `N_RD_PORTS` x `RSV_ID_W`  bypass lookup tags.
- `rd_data`  out  `N_RD_PORTS` x `DATA_W`  entry data (combinational).
- `rd_done`  out  `N_RD_PORTS`  entry busy and done (combinational).
- `we`  out  1  commit strobe (registered).
- `we_invalidate`  out  1  commit without data update (registered).
- `wrQueAddr`  out  `RSV_ID_W`  committed tag (registered).
- `wrAddr`  out  `REG_ADDR_W`  committed register (registered).
- `wrData`  out  `DATA_W`  committed data (registered).
- `empty`  out  1  no busy entries.
- `full`  out  1  all entries busy.

Behaviour:
- Storage and pointers:
  - Each entry holds `busy`, `done`, `has_dest`, `inval`, `reg_addr` and `data`.
  - `head` and `tail` are `RSV_ID_W`+1 bits wide; the MSB is the wrap bit.
  - `empty` = (`head` == `tail`). `full` = index bits equal and wrap bits differ.
  - Indices wrap modulo 2**`RSV_ID_W` with no special case.
- Reset (`rst` high at an edge):
  - `head` = `tail` = 0; all `busy`/`done` cleared.
  - `we` = 0, `we_invalidate` = 0, `wrQueAddr` = 0, `wrAddr` = 0, `wrData` = 0.
  - Hence `alloc_id` = 0, `alloc_ready` = 1, `empty` = 1, `full` = 0.
  - Reset overrides every other input, including while a commit is pending.
- Allocate (`alloc_valid` && `alloc_ready`):
  - Entry[`tail`] gets `busy`=1, `done`=0, `inval`=0, plus `has_dest` and `reg_addr` from the inputs.
  - `tail` increments.
  - `alloc_ready` does not account for a same-cycle commit. When full, allocation stalls one cycle even if the head retires that cycle.
- Result write (`cdb_valid`):
  - If entry[`cdb_id`] is busy: `done`=1, `data`=`cdb_data`, `inval`=`cdb_invalidate`.
  - A write to a non-busy entry is ignored.
  - A second write to an already-done entry overwrites it; last write wins.
- Commit (evaluated every edge):
  - Condition: `head` entry busy && done.
  - If the entry has a destination: `we`=1 and `we_invalidate`=`inval`, with `wrQueAddr`/`wrAddr`/`wrData` taken from the entry.
  - If it has no destination: `we`=0; the entry is retired silently.
  - In both cases `busy`=0 and `head` increments.
  - Otherwise `we`=0 and `we_invalidate`=0; the data outputs hold their last values.
  - At most one commit per cycle.
- Latency:
  - `done` set at edge N permits commit at edge N+1.
  - Minimum is allocate at edge E0, result at E1, `we` high after E2.
  - A result for the head entry never commits in its own cycle.
- Simultaneous events:
  - Allocate, result write and commit may all occur in the same cycle.
  - A result arriving for the entry being allocated that same cycle is illegal (the tag is not yet issued); behaviour is unspecified.
- Flush (highest priority after reset):
  - Clears all `busy`, sets `head` = `tail` = 0, and forces `we`=0 and `we_invalidate`=0 at that edge.
  - Allocate, result write and commit in the flush cycle are discarded.
  - Any commit already on the outputs before the edge completes normally.
- Bypass reads: `rd_done[i]` = `busy` && `done` of entry[`rd_ids[i]`]; `rd_data[i]` = that entry's data, or don't-care when not done.

Decomposition:
- Add to `fcpu_pkg`:
  - `ROB_DEPTH` = 2**`RSV_ID_W`.
  - `ROB_PTR_W` = `RSV_ID_W`+1.
  - A packed struct `rob_entry_t` {`busy`, `done`, `has_dest`, `inval`, `reg_addr`, `data`}.
- One sub-module, `rob_ptr`: a wrap-bit pointer with increment, clear, and the full/empty compare.
- Everything else stays in a single module.

Test Plan (`RSV_ID_W`=3, `DATA_W`=32):
1. Reset, allocate r5 (tag 0), result tag 0 = 0x1234 -> 2 cycles after the allocate cycle: `we`=1, `wrQueAddr`=0, `wrAddr`=5, `wrData`=0x1234, for exactly one cycle; then `empty`=1.
2. Allocate tags 0,1,2 (r1,r2,r3); results in order 2,0,1 -> commits appear in tag order 0,1,2 on consecutive cycles; no commit before tag 0 is done.
3. Allocate 8 entries -> `full`=1, `alloc_ready`=0, `alloc_id`=0. Complete tag 0 -> one commit, then `alloc_ready`=1. The 9th allocation returns tag 0 with the wrap bit set, and it commits correctly.
4. Result for tag 3 with `cdb_invalidate`=1 -> commit shows `we`=1, `we_invalidate`=1, `wrQueAddr`=3. A no-dest entry -> retires with `we`=0 and `head` advances.
5. Four busy entries, two done; assert `flush` -> next cycle `empty`=1, `alloc_id`=0, `we`=0. A stale result for old tag 1 is ignored.
6. Tag 4 done with 0xCAFE, not yet committed -> `rd_ids[0]`=4 gives `rd_done[0]`=1, `rd_data[0]`=0xCAFE. A not-done tag gives `rd_done`=0. Assert `rst` mid-stream -> all outputs return to their reset values.
